// File: rtl/shift_display_controller.sv
// Four-digit entry register with seven-segment (active-low, {g..a}) display outputs.
// Define SDC_BLANK_UNUSED_EN to blank the display of digits that have not been written since reset/restart.
module shift_display_controller (
    input  logic        clk,
    input  logic        sys_reset,
    input  logic        restart_pulse,
    input  logic        store_digit_pulse,
    input  logic [2:0]  digit_count,
    input  logic [3:0]  current_digit,
    output logic [15:0] entered_code,
    output logic [6:0]  HEX5,
    output logic [6:0]  HEX4,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX2
);

`ifdef SDC_BLANK_UNUSED_EN
    localparam logic BLANK_UNUSED = 1'b1;
`else
    localparam logic BLANK_UNUSED = 1'b0;
`endif

    // Index 3 holds d3, so the packed array is already {d3,d2,d1,d0}.
    logic [3:0][3:0] digit_q, digit_d;
    logic [3:0]      valid_q, valid_d;
    logic [1:0]      wr_idx;
    logic [3:0][6:0] hex_img;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    // Position 0 addresses d3, so the register index is 3 - position.
    assign wr_idx = ~digit_count[1:0];

    always_comb begin
        digit_d = digit_q;
        valid_d = valid_q;
        if (restart_pulse) begin
            digit_d = '0;
            valid_d = '0;
        end else if (store_digit_pulse && !digit_count[2]) begin
            digit_d[wr_idx] = current_digit;
            valid_d[wr_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge sys_reset) begin
        if (!sys_reset) begin
            digit_q <= '0;
            valid_q <= '0;
        end else begin
            digit_q <= digit_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            hex_img[i] = (BLANK_UNUSED && !valid_q[i]) ? 7'h7F : seg7(digit_q[i]);
        end
    end

    assign entered_code = digit_q;
    assign HEX5 = hex_img[3];
    assign HEX4 = hex_img[2];
    assign HEX3 = hex_img[1];
    assign HEX2 = hex_img[0];

endmodule

// File: tb/tb_shift_display_controller.sv
// Bench for shift_display_controller: directed vector table, multi-cycle corner sequences and
// randomized traffic against a digit-array reference model. Honors SDC_BLANK_UNUSED_EN if defined.
module tb_shift_display_controller;

`ifdef SDC_BLANK_UNUSED_EN
    localparam logic       BLANK = 1'b1;
    localparam logic [6:0] U     = 7'h7F;
`else
    localparam logic       BLANK = 1'b0;
    localparam logic [6:0] U     = 7'h40;
`endif

    logic        clk = 1'b0;
    logic        sys_reset;
    logic        restart_pulse;
    logic        store_digit_pulse;
    logic [2:0]  digit_count;
    logic [3:0]  current_digit;
    logic [15:0] entered_code;
    logic [6:0]  HEX5, HEX4, HEX3, HEX2;

    int checks = 0;
    int failures = 0;

    // Reference model: m_d[p] / m_v[p] for write position p (0 = leftmost digit d3).
    int m_d[4];
    bit m_v[4];

    shift_display_controller dut (
        .clk               (clk),
        .sys_reset         (sys_reset),
        .restart_pulse     (restart_pulse),
        .store_digit_pulse (store_digit_pulse),
        .digit_count       (digit_count),
        .current_digit     (current_digit),
        .entered_code      (entered_code),
        .HEX5              (HEX5),
        .HEX4              (HEX4),
        .HEX3              (HEX3),
        .HEX2              (HEX2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        restart;
        logic        store;
        logic [2:0]  cnt;
        logic [3:0]  val;
        logic [15:0] exp_code;
        logic [6:0]  exp_h5, exp_h4, exp_h3, exp_h2;
    } vec_t;

    function automatic logic [6:0] seg_of(input int d);
        logic [6:0] tbl [10];
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        return (d <= 9) ? tbl[d] : 7'h7F;
    endfunction

    function automatic logic [15:0] m_code();
        return 16'(m_d[0] * 4096 + m_d[1] * 256 + m_d[2] * 16 + m_d[3]);
    endfunction

    function automatic logic [6:0] m_hex(input int p);
        return (BLANK && !m_v[p]) ? 7'h7F : seg_of(m_d[p]);
    endfunction

    task automatic m_clear();
        for (int p = 0; p < 4; p++) begin
            m_d[p] = 0;
            m_v[p] = 0;
        end
    endtask

    task automatic m_edge(input logic rs, input logic st, input logic [2:0] c, input logic [3:0] v);
        if (rs) m_clear();
        else if (st && c <= 3) begin
            m_d[c] = int'(v);
            m_v[c] = 1;
        end
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [15:0] code,
                           input logic [6:0] h5, input logic [6:0] h4,
                           input logic [6:0] h3, input logic [6:0] h2);
        chk({tag, ".code"}, entered_code, code);
        chk({tag, ".HEX5"}, {9'd0, HEX5}, {9'd0, h5});
        chk({tag, ".HEX4"}, {9'd0, HEX4}, {9'd0, h4});
        chk({tag, ".HEX3"}, {9'd0, HEX3}, {9'd0, h3});
        chk({tag, ".HEX2"}, {9'd0, HEX2}, {9'd0, h2});
    endtask

    task automatic chk_model(input string tag);
        chk_all(tag, m_code(), m_hex(0), m_hex(1), m_hex(2), m_hex(3));
    endtask

    // Inputs are driven at the falling edge; one posedge captures them and outputs are sampled at the next falling edge.
    task automatic drive_step(input logic rs, input logic st, input logic [2:0] c, input logic [3:0] v);
        restart_pulse     = rs;
        store_digit_pulse = st;
        digit_count       = c;
        current_digit     = v;
        @(posedge clk);
        @(negedge clk);
        m_edge(rs, st, c, v);
    endtask

    vec_t vecs [14];

    initial begin
        vecs[0]  = '{0, 1, 3'd0, 4'd1,  16'h1000, 7'h79, U,     U,     U};
        vecs[1]  = '{0, 1, 3'd1, 4'd2,  16'h1200, 7'h79, 7'h24, U,     U};
        vecs[2]  = '{0, 1, 3'd2, 4'd3,  16'h1230, 7'h79, 7'h24, 7'h30, U};
        vecs[3]  = '{0, 1, 3'd3, 4'd4,  16'h1234, 7'h79, 7'h24, 7'h30, 7'h19};
        vecs[4]  = '{1, 0, 3'd0, 4'd0,  16'h0000, U,     U,     U,     U};
        vecs[5]  = '{0, 1, 3'd0, 4'd9,  16'h9000, 7'h10, U,     U,     U};
        vecs[6]  = '{0, 1, 3'd1, 4'd8,  16'h9800, 7'h10, 7'h00, U,     U};
        vecs[7]  = '{0, 1, 3'd2, 4'd7,  16'h9870, 7'h10, 7'h00, 7'h78, U};
        vecs[8]  = '{0, 1, 3'd3, 4'd6,  16'h9876, 7'h10, 7'h00, 7'h78, 7'h02};
        vecs[9]  = '{0, 1, 3'd5, 4'd1,  16'h9876, 7'h10, 7'h00, 7'h78, 7'h02};
        vecs[10] = '{0, 0, 3'd0, 4'd5,  16'h9876, 7'h10, 7'h00, 7'h78, 7'h02};
        vecs[11] = '{1, 1, 3'd0, 4'd5,  16'h0000, U,     U,     U,     U};
        vecs[12] = '{0, 1, 3'd0, 4'd1,  16'h1000, 7'h79, U,     U,     U};
        vecs[13] = '{0, 1, 3'd3, 4'd12, 16'h100C, 7'h79, U,     U,     7'h7F};

        sys_reset = 1'b0;
        restart_pulse = 1'b0;
        store_digit_pulse = 1'b1;
        digit_count = 3'd0;
        current_digit = 4'd7;
        m_clear();
        @(posedge clk);
        @(negedge clk);
        chk_all("reset", 16'h0000, U, U, U, U);
        store_digit_pulse = 1'b0;
        sys_reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            drive_step(vecs[i].restart, vecs[i].store, vecs[i].cnt, vecs[i].val);
            chk_all($sformatf("vec%0d", i), vecs[i].exp_code,
                    vecs[i].exp_h5, vecs[i].exp_h4, vecs[i].exp_h3, vecs[i].exp_h2);
        end

        // Held strobe rewrites the same digit every cycle, leaving the others alone.
        drive_step(0, 1, 3'd1, 4'd3);
        chk("hold.c1", entered_code, 16'h130C);
        drive_step(0, 1, 3'd1, 4'd15);
        chk("hold.c2", entered_code, 16'h1F0C);
        drive_step(0, 1, 3'd1, 4'd5);
        chk_model("hold.c3");
        chk("hold.code", entered_code, 16'h150C);

        // Reset dropped between edges clears immediately; strobes during reset are ignored.
        restart_pulse = 1'b0;
        store_digit_pulse = 1'b1;
        digit_count = 3'd2;
        current_digit = 4'd9;
        #2 sys_reset = 1'b0;
        #1 chk("async_rst.code", entered_code, 16'h0000);
        m_clear();
        @(posedge clk);
        @(negedge clk);
        chk_all("in_rst", 16'h0000, U, U, U, U);
        store_digit_pulse = 1'b0;
        sys_reset = 1'b1;
        @(negedge clk);
        chk_model("post_rst");

        for (int n = 0; n < 300; n++) begin
            logic rs, st;
            logic [2:0] c;
            logic [3:0] v;
            rs = ($urandom_range(0, 15) == 0);
            st = ($urandom_range(0, 3) != 0);
            c  = 3'($urandom_range(0, 7));
            v  = 4'($urandom_range(0, 15));
            drive_step(rs, st, c, v);
            chk_model($sformatf("rand%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shift_display_controller.md
SHIFT_DISPLAY_CONTROLLER -- requirements
Module: shift_display_controller

Interface
REQ-001 The module SHALL use one clock, clk; sys_reset SHALL be an asynchronous, active-low reset.
REQ-002 clk  input  1  system clock; all state changes SHALL occur on its rising edge, except reset.
REQ-003 sys_reset  input  1  asynchronous active-low reset.
REQ-004 restart_pulse  input  1  synchronous clear of all stored digits, sampled active-high.
REQ-005 store_digit_pulse  input  1  synchronous write strobe, sampled active-high.
REQ-006 digit_count  input  3  write position: 0=d3, 1=d2, 2=d1, 3=d0; values 4-7 SHALL be ignored.
REQ-007 current_digit  input  4  value to store (BCD, 0-9 nominal).
REQ-008 entered_code  output  16  {d3,d2,d1,d0}, where d3 is in bits 15:12.
REQ-009 HEX5  output  7  seven-segment image of d3, active-low, bit order {g,f,e,d,c,b,a}.
REQ-010 HEX4  output  7  image of d2; HEX3  output  7  image of d1; HEX2  output  7  image of d0.

Function
REQ-011 The module SHALL hold four 4-bit digit registers d3..d0 and four valid flags v3..v0.
REQ-012 Store operation:
- Condition: store_digit_pulse=1, restart_pulse=0 and digit_count<=3 at a rising edge.
- Effect: the addressed digit SHALL load current_digit and its valid flag SHALL set to 1.
- Other digits and flags SHALL be unchanged.
REQ-013 When store_digit_pulse is held high for N cycles, the addressed digit SHALL be rewritten each cycle; no other side effect SHALL occur.
REQ-014 current_digit values 10-15 SHALL be stored unmodified.
REQ-015 When digit_count is 4-7, the store SHALL be ignored and no register SHALL change.
REQ-016 When restart_pulse=1 at a rising edge, all digits SHALL clear to 0 and all valid flags SHALL clear to 0.
REQ-017 When restart_pulse and store_digit_pulse are both 1 at the same edge, restart SHALL win and no store SHALL occur.
REQ-018 entered_code and HEX outputs SHALL be combinational from the registers and SHALL reflect a store in the same cycle as the capturing edge (0-cycle output latency after the edge).
REQ-019 Segment encoding (hex, {g..a}) SHALL be:
- 0=40, 1=79, 2=24, 3=30, 4=19
- 5=12, 6=02, 7=78, 8=00, 9=10
- 10-15=7F (blank)
REQ-020 The module SHALL contain no further state; no handshake or acknowledge output SHALL exist.

Reset
REQ-021 While sys_reset=0, all digits and valid flags SHALL clear to 0 immediately, regardless of clk.
REQ-022 Resulting outputs during reset:
- entered_code=16'h0000.
- HEX5..HEX2=7'h40, or 7'h7F when SDC_BLANK_UNUSED_EN is defined.
REQ-023 Reset asserted mid-sequence SHALL discard all partially entered digits; restart_pulse and store_digit_pulse SHALL be ignored while reset is asserted.

Configuration
REQ-024 Macro SDC_BLANK_UNUSED_EN:
- Defined: each HEX output whose digit valid flag is 0 SHALL show 7'h7F.
- Not defined: valid flags SHALL NOT affect the display, and an unwritten digit SHALL show 7'h40 ("0").
- In both cases entered_code SHALL be unaffected by the macro.

Verification
REQ-025 Release reset; store 1,2,3,4 with digit_count 0,1,2,3 (one-cycle pulses):
- entered_code=16'h1234.
- HEX5=79, HEX4=24, HEX3=30, HEX2=19.
REQ-026 One-cycle restart_pulse after REQ-025:
- entered_code=16'h0000.
- HEX5..HEX2=40, or 7F with the macro defined.
REQ-027 Store 9,8,7,6 at positions 0-3:
- entered_code=16'h9876.
- HEX5=10, HEX4=00, HEX3=78, HEX2=02.
REQ-028 Boundary cases, from code 16'h9876:
- store with digit_count=5 -> entered_code unchanged.
- restart_pulse and store_digit_pulse asserted in the same cycle -> entered_code=16'h0000.
REQ-029 Store 1 at position 0 only, then store 12 at position 3:
- Macro defined: HEX5=79, HEX4=7F, HEX3=7F, HEX2=7F.
- Macro undefined: HEX4=40, HEX3=40, HEX2=7F.
REQ-030 Assert sys_reset=0 between clock edges mid-sequence:
- entered_code SHALL go to 16'h0000 before the next rising edge.
